// File: rtl/activations_status_in.sv
// Avalon-MM status input port: synchronises WIDTH external inputs, latches edges, raises a maskable IRQ.
// Optional debounce filter on data_reg is enabled by defining ACTIVATIONS_STATUS_IN_DEBOUNCE_EN.
module activations_status_in #(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Bus handshake: chipselect qualifies every access, write_n selects direction;
  // the slave has no wait states, so every selected cycle completes in that clock.
  logic             wr;
  logic             rd;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_dly;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] clear_bits;
  logic [31:0]      rd_mux;
  logic             unused_writedata;

  assign wr = chipselect & ~write_n;
  assign rd = chipselect & write_n;
  assign unused_writedata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef ACTIVATIONS_STATUS_IN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] db_cnt [WIDTH];

  // Each bit's counter runs only while the synchronised input disagrees with data_reg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= '0;
      for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == data_reg[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          data_reg[i] <= sync2[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (DEBOUNCE_CYCLES < 2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_reg <= '0;
    else          data_reg <= sync2;
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) data_dly <= '0;
    else          data_dly <= data_reg;
  end

  always_comb begin
    edge_det = data_reg & ~data_dly;
    case (EDGE_TYPE)
      1:       edge_det = ~data_reg & data_dly;
      2:       edge_det = data_reg ^ data_dly;
      default: edge_det = data_reg & ~data_dly;
    endcase
  end

  assign clear_bits = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  // OR-ing edge_det after the clear makes a same-cycle edge win over W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edgecapture <= '0;
      irqmask     <= '0;
      irq         <= 1'b0;
    end else begin
      edgecapture <= (edgecapture & ~clear_bits) | edge_det;
      if (wr && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      irq <= |(edgecapture & irqmask);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = data_reg;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  readdata <= '0;
    else if (rd)   readdata <= rd_mux;
  end

endmodule

// File: tb/tb_activations_status_in.sv
// Directed table-driven bench for activations_status_in (WIDTH=4, rising edges).
// Debounce sequence runs when ACTIVATIONS_STATUS_IN_DEBOUNCE_EN is defined.
module tb_activations_status_in;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks;
  int errors;
  logic [31:0] exp_q[$];
  logic [31:0] rdv;

`ifdef ACTIVATIONS_STATUS_IN_DEBOUNCE_EN
  localparam int SETTLE = 24;
`else
  localparam int SETTLE = 6;
`endif

  typedef struct packed {
    logic [3:0]  in_val;
    logic        do_wr;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [15];

  activations_status_in #(.WIDTH(4), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: all start and end on a negedge
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk); @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(2);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 4'hF;

    tbl[0]  = '{4'h0, 1'b0, 2'd0, 32'h0,         2'd0, 32'h0, 1'b0};
    tbl[1]  = '{4'h0, 1'b1, 2'd2, 32'h2,         2'd2, 32'h2, 1'b0};
    tbl[2]  = '{4'h2, 1'b0, 2'd0, 32'h0,         2'd0, 32'h2, 1'b1};
    tbl[3]  = '{4'h2, 1'b0, 2'd0, 32'h0,         2'd3, 32'h2, 1'b1};
    tbl[4]  = '{4'h2, 1'b1, 2'd3, 32'h0,         2'd3, 32'h2, 1'b1};
    tbl[5]  = '{4'h2, 1'b1, 2'd3, 32'h2,         2'd3, 32'h0, 1'b0};
    tbl[6]  = '{4'h2, 1'b1, 2'd0, 32'hF,         2'd0, 32'h2, 1'b0};
    tbl[7]  = '{4'h2, 1'b1, 2'd1, 32'hF,         2'd1, 32'h0, 1'b0};
    tbl[8]  = '{4'hA, 1'b0, 2'd0, 32'h0,         2'd3, 32'h8, 1'b0};
    tbl[9]  = '{4'hA, 1'b1, 2'd2, 32'h8,         2'd2, 32'h8, 1'b1};
    tbl[10] = '{4'hA, 1'b1, 2'd2, 32'h0,         2'd3, 32'h8, 1'b0};
    tbl[11] = '{4'h0, 1'b1, 2'd3, 32'hF,         2'd3, 32'h0, 1'b0};
    tbl[12] = '{4'h5, 1'b1, 2'd2, 32'hF,         2'd3, 32'h5, 1'b1};
    tbl[13] = '{4'h5, 1'b1, 2'd3, 32'h1,         2'd3, 32'h4, 1'b1};
    tbl[14] = '{4'h5, 1'b1, 2'd2, 32'hFFFF_FFF0, 2'd2, 32'h0, 1'b0};

    // reset held with inputs toggling: outputs stay 0
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_port = (i % 2 == 0) ? 4'hF : 4'h0;
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
    end
    in_port = 4'h0;
    reset_n = 1'b1;
    cycles(SETTLE);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rdv);
      check("post_reset_reg", rdv, 32'h0);
    end

`ifdef ACTIVATIONS_STATUS_IN_DEBOUNCE_EN
    // 10-cycle glitch is filtered out
    in_port = 4'h2;
    cycles(10);
    in_port = 4'h0;
    cycles(30);
    bus_read(2'd0, rdv);
    check("db_glitch", rdv, 32'h0);
    // long pulse: data_reg updates at N+17, visible in readdata one edge later
    in_port = 4'h2; address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 17) check("db_n17_before", readdata, 32'h0);
      if (k == 18) check("db_n17_after", readdata, 32'h2);
    end
    chipselect = 1'b0;
    cycles(4);
    in_port = 4'h0;
    do_reset();
    cycles(SETTLE);
`endif

    // table-driven vectors
    for (int v = 0; v < 15; v++) begin
      in_port = tbl[v].in_val;
      cycles(SETTLE);
      if (tbl[v].do_wr) bus_write(tbl[v].wr_addr, tbl[v].wr_data);
      cycles(2);
      exp_q.push_back(tbl[v].exp_rd);
      exp_q.push_back({31'h0, tbl[v].exp_irq});
      bus_read(tbl[v].rd_addr, rdv);
      check($sformatf("tbl%0d_rd", v), rdv, exp_q.pop_front());
      check($sformatf("tbl%0d_irq", v), {31'h0, irq}, exp_q.pop_front());
    end

`ifndef ACTIVATIONS_STATUS_IN_DEBOUNCE_EN
    // exact latency: data_reg at N+2
    in_port = 4'h0;
    cycles(SETTLE);
    bus_write(2'd3, 32'hF);
    in_port = 4'h2; address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 2) check("lat_data_n2", readdata, 32'h0);
      if (k == 3) check("lat_data_n3", readdata, 32'h2);
    end
    chipselect = 1'b0;
    in_port = 4'h0;
    cycles(SETTLE);
    bus_write(2'd3, 32'hF);
    bus_write(2'd2, 32'h2);
    // edgecapture at N+3, irq at N+4
    in_port = 4'h2; address = 2'd3; chipselect = 1'b1; write_n = 1'b1;
    for (int k = 0; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (k == 3) begin
        check("lat_ec_n3", readdata, 32'h0);
        check("lat_irq_n3", {31'h0, irq}, 32'h0);
      end
      if (k == 4) begin
        check("lat_ec_n4", readdata, 32'h2);
        check("lat_irq_n4", {31'h0, irq}, 32'h1);
      end
    end
    chipselect = 1'b0;
    // W1C: irq falls one clock after the clear
    bus_write(2'd3, 32'h2);
    check("w1c_irq_lag", {31'h0, irq}, 32'h1);
    @(posedge clk); @(negedge clk);
    check("w1c_irq_low", {31'h0, irq}, 32'h0);
    bus_read(2'd3, rdv);
    check("w1c_ec", rdv, 32'h0);

    // set wins: W1C of bit0 lands on the edge that captures bit0
    in_port = 4'h3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, rdv);
    check("set_wins", rdv, 32'h1);
    cycles(3);
    check("rd_hold", readdata, 32'h1);
`endif

    // asynchronous reset mid-operation with inputs high
    in_port = 4'hF;
    cycles(SETTLE);
    bus_write(2'd2, 32'hF);
    bus_read(2'd3, rdv);
    cycles(2);
    check("pre_mid_irq", {31'h0, irq}, 32'h1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("mid_reset_rd", readdata, 32'h0);
    check("mid_reset_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    cycles(SETTLE);
    bus_read(2'd2, rdv);
    check("mid_reset_mask", rdv, 32'h0);
    bus_read(2'd3, rdv);
    check("mid_reset_rise", rdv, 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
